// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl_if
// Purpose  : Bundles the operand/result handshake and the full-adder link of
//            the bit-serial adder controller.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals (direction seen from the controller, i.e. the slave modport):
//   start      in   request to begin an addition
//   a, b       in   N-bit operands, sampled on an accepted start
//   cin        in   carry-in, sampled on an accepted start
//   fa_x/y/z   out  bit pair and carry presented to the external full adder
//   fa_s, fa_c in   sum and carry returned by the external full adder
//   busy       out  high while bits are being shifted
//   done       out  one-cycle pulse when sum/cout become valid
//   sum, cout  out  result, held until the next accepted start
// The master modport is the environment: requester plus full adder.
// ============================================================================
interface serial_adder_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         fa_x;
  logic         fa_y;
  logic         fa_z;
  logic         fa_s;
  logic         fa_c;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport slave (
    input  start, a, b, cin, fa_s, fa_c,
    output fa_x, fa_y, fa_z, busy, done, sum, cout
  );

  modport master (
    output start, a, b, cin, fa_s, fa_c,
    input  fa_x, fa_y, fa_z, busy, done, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Purpose  : Bit-serial addition controller. Loads two N-bit operands and a
//            carry-in, feeds one bit pair per clock to an external full
//            adder, recirculates its carry and collects the sum bits LSB
//            first. {cout, sum} = a + b + cin after N shift cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of serial_adder_ctrl_if (handshake + adder link)
// Parameters:
//   N      operand/result width, 2..32 (must match the interface N)
// ============================================================================
module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_adder_ctrl_if.slave     bus
);

  localparam int             CW       = $clog2(N + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  sum_reg;
  logic          carry_reg;
  logic [CW-1:0] cnt;

  // Published result; separate from sum_reg so partial sums never show.
  logic [N-1:0]  sum_out;
  logic          cout_out;

  logic          load;
  logic          shift_en;
  logic          last;
  logic [N-1:0]  sum_shift;

  // New sum bit enters at the MSB; after N shifts the first (LSB) bit
  // computed has reached bit 0.
  assign sum_shift = N'({bus.fa_s, sum_reg} >> 1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // start is deliberately ignored here; operands stay as loaded.
        shift_en = 1'b1;
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Accepting start here gives back-to-back additions.
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      sum_out   <= '0;
      cout_out  <= 1'b0;
    end else if (load) begin
      a_reg     <= bus.a;
      b_reg     <= bus.b;
      carry_reg <= bus.cin;
      cnt       <= '0;
    end else if (shift_en) begin
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      sum_reg   <= sum_shift;
      carry_reg <= bus.fa_c;
      cnt       <= cnt + CW'(1);
      // The final shift lands directly in the output registers so the
      // result appears together with done.
      if (last) begin
        sum_out  <= sum_shift;
        cout_out <= bus.fa_c;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.fa_x = a_reg[0];
  assign bus.fa_y = b_reg[0];
  assign bus.fa_z = carry_reg;
  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_out;
  assign bus.cout = cout_out;

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that wraps the single-bit full-adder stage. It loads two N-bit operands and a carry-in, then presents one bit pair per clock to an external full-adder instance. The full adder's carry is fed back through a carry register, and its sum bits are collected into an N-bit result. The block sits directly upstream and downstream of the full adder: it drives the adder's `x`/`y`/`z` inputs and consumes its `S`/`C` outputs.

## Interface
Parameters:
- `N`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin an addition; sampled only in IDLE or DONE.
- `a`  in  N  operand A; sampled on the accepted `start`.
- `b`  in  N  operand B; sampled on the accepted `start`.
- `cin`  in  1  carry-in; sampled on the accepted `start`.
- `fa_x`  out  1  to full adder `x`; equals `a_reg[0]`.
- `fa_y`  out  1  to full adder `y`; equals `b_reg[0]`.
- `fa_z`  out  1  to full adder `z`; equals `carry_reg`.
- `fa_s`  in  1  from full adder `S`.
- `fa_c`  in  1  from full adder `C`.
- `busy`  out  1  high while bits are being shifted (SHIFT state).
- `done`  out  1  one-cycle pulse when `sum`/`cout` become valid.
- `sum`  out  N  result; held stable from `done` until the next accepted `start`.
- `cout`  out  1  final carry; held with `sum`.

## Operation
- Internal state:
  - `a_reg`, `b_reg`, `sum_reg`: N bits each.
  - `carry_reg`: 1 bit.
  - `cnt`: `$clog2(N+1)` bits.
  - FSM with three states: IDLE, SHIFT, DONE.
- Reset (async, `rst_n`=0): FSM enters IDLE and every register clears to 0. As a result, `busy`=0, `done`=0, `sum`=0, `cout`=0, `fa_x`=`fa_y`=`fa_z`=0.
- The `fa_*` outputs are pure combinational functions of registers. The full-adder path is combinational within one cycle.
- IDLE:
  - `start`=1 loads `a_reg`<=`a`, `b_reg`<=`b`, `carry_reg`<=`cin`, `cnt`<=0, and moves to SHIFT.
  - `sum`/`cout` keep their previous values until the new result lands.
- SHIFT, on each cycle:
  - `sum_reg` <= {`fa_s`, `sum_reg[N-1:1]`}, i.e. the LSB is computed first and ends up in bit 0 after N shifts.
  - `a_reg` and `b_reg` shift right by one, zero-filled.
  - `carry_reg` <= `fa_c`.
  - `cnt` <= `cnt`+1.
- SHIFT exit: when `cnt`==N-1 at the edge, the Nth shift occurs and the FSM moves to DONE.
- `sum` = `sum_reg` and `cout` = `carry_reg`, but both outputs are updated only on the SHIFT→DONE edge. They never show partial results.
- DONE: `done`=1 for exactly this one cycle.
  - `start`=1 in DONE is accepted with the same load action as IDLE, giving back-to-back operation.
  - Otherwise the FSM returns to IDLE.
- `start` during SHIFT is ignored; operands are not resampled.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, computed modulo 2^(N+1).

## Timing
- Cycle 0 is the edge that samples `start`=1.
- Cycles 1..N are SHIFT edges, with `busy`=1 during the cycles that follow edges 0..N-1.
- `done`=1 in the cycle after edge N, so latency is start edge to `done` = N+1 edges (9 for N=8).
- Throughput: one addition per N+1 cycles with back-to-back `start` in DONE.
- `rst_n` asserted mid-SHIFT:
  - Immediate abort to IDLE with all outputs 0.
  - No `done` is produced.
  - After release, the block waits for a fresh `start`.
- Simultaneous `start` and reset release: `start` is honoured only on the first edge where `rst_n`=1 at the edge.

## Test plan
- N=8, a=8'h3C, b=8'h0F, cin=0 -> `done` at edge 9 with `sum`=8'h4B, `cout`=0; `busy` high exactly 8 cycles.
- a=8'hFF, b=8'h01, cin=0 -> `sum`=8'h00, `cout`=1. Also a=8'hFF, b=8'hFF, cin=1 -> `sum`=8'hFF, `cout`=1.
- Start a=8'h12, b=8'h34. Pulse `start` with a=8'hAA, b=8'h55 at SHIFT cycle 3 -> result is still 8'h46, `cout`=0, and exactly one `done` occurs.
- Assert `rst_n`=0 at SHIFT cycle 4 of a=8'h80, b=8'h80 -> `busy`/`sum`/`cout`/`fa_*` go to 0 immediately with no `done`. A new start of 8'h01+8'h01 then yields 8'h02.
- Hold `start` high continuously with a=8'h01, b=8'h02, cin=1 -> a `done` pulse every 9 cycles with `sum`=8'h04, and `sum` stable between pulses.
- Random sweep of 1000 operand/cin triples for N=8 and N=4 against a + b + cin -> zero mismatches. `fa_z` on each SHIFT cycle must equal the expected ripple carry into that bit.
